// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for an 8-bit x 16-deep FIFO.
// Snoops the writer's strobe to keep a shadow occupancy count and issues
// reads only when the FIFO holds data. Read data is re-timed into a
// 2-entry skid buffer and presented on a valid/ready stream.
module fifo_drain_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_wr_n,
  output logic              fifo_rd_n,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_over_flow,
  input  logic              fifo_under_flow,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  level,
  output logic              err_ovf,
  output logic              err_udf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t state, state_nxt;

  logic              inflight;       // a read was issued last cycle
  logic [1:0]        buf_cnt;        // skid buffer occupancy, 0..2
  logic [DATA_W-1:0] buf_q [2];      // entry 0 is the head

  logic       pop;
  logic       push;
  logic       wr_req;
  logic       wr_cnt;
  logic       wr_full;
  logic       level_nz;
  logic       slot_free;
  logic       rd_en;
  logic [2:0] occ;

  // Stream handshake and snooped write qualification.
  assign pop      = m_valid & m_ready;
  assign push     = inflight;
  assign wr_req   = ~fifo_wr_n;
  assign wr_cnt   = wr_req && (level < DEPTH_C);
  assign wr_full  = wr_req && (level == DEPTH_C);
  assign level_nz = (level != '0);

  // Words already committed to the buffer (held plus landing, minus leaving).
  // This can never go negative because pop implies buf_cnt > 0.
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign slot_free = (occ < 3'd2);

  // Downstream stream view of the skid buffer head.
  assign m_valid = (buf_cnt != 2'd0);
  assign m_data  = buf_q[0];

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample
    // pre-edge values; blocking here would make results depend on order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable && level_nz) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!enable)
          state_nxt = FLUSH;
        else if (!level_nz && !inflight && (buf_cnt == 2'd0))
          state_nxt = IDLE;
      end
      FLUSH: begin
        if (!inflight && (buf_cnt == 2'd0)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: issue a read only with data present and a guaranteed slot.
  always_comb begin
    rd_en     = enable && level_nz && (state != FLUSH) && slot_free;
    fifo_rd_n = ~rd_en;
  end

  // In-flight flag: read data appears on fifo_dout one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= rd_en;
  end

  // Shadow occupancy: snooped writes up, own reads down.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      unique case ({wr_cnt, rd_en})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_full || fifo_over_flow) err_ovf <= 1'b1;
      if (fifo_under_flow)           err_udf <= 1'b1;
    end
  end

  // Two-entry skid buffer: landing word goes to the tail, pops shift forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data entries are reset too because m_data must read 0
      // out of reset; storage without such a requirement would skip it.
      buf_cnt  <= 2'd0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) buf_q[0] <= fifo_dout;
          else                 buf_q[1] <= fifo_dout;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_q[0] <= buf_q[1];
          buf_cnt  <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_q[0] <= fifo_dout;
          end else begin
            buf_q[0] <= buf_q[1];
            buf_q[1] <= fifo_dout;
          end
        end
        default: begin
          buf_cnt <= buf_cnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl. A queue-based FIFO model feeds
// the DUT; every accepted write is expected on the output stream in order.
module tb_fifo_drain_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              fifo_wr_n;
  logic              fifo_rd_n;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_over_flow;
  logic              fifo_under_flow;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [CNT_W-1:0]  level;
  logic              err_ovf;
  logic              err_udf;
  logic [DATA_W-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fq[$];      // contents of the modelled FIFO
  logic [DATA_W-1:0] exp_q[$];   // words still owed on the output stream
  logic [DATA_W-1:0] got[$];     // words delivered, for per-test order checks
  bit                exp_ovf;
  bit                exp_udf;
  bit                stall_pending;
  logic [DATA_W-1:0] stall_data;

  fifo_drain_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .fifo_wr_n       (fifo_wr_n),
    .fifo_rd_n       (fifo_rd_n),
    .fifo_dout       (fifo_dout),
    .fifo_over_flow  (fifo_over_flow),
    .fifo_under_flow (fifo_under_flow),
    .m_valid         (m_valid),
    .m_data          (m_data),
    .m_ready         (m_ready),
    .level           (level),
    .err_ovf         (err_ovf),
    .err_udf         (err_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  // One clock cycle: sample pre-edge values at the falling edge, check the
  // stream, then advance the FIFO/error model after the rising edge.
  task automatic tick();
    logic s_rst, s_rd_n, s_wr_n, s_valid, s_ready, s_ovf, s_udf, full;
    logic [DATA_W-1:0] s_data, s_wdata, exp;
    @(negedge clk);
    s_rst = rst;     s_rd_n = fifo_rd_n; s_wr_n = fifo_wr_n;
    s_valid = m_valid; s_ready = m_ready; s_data = m_data;
    s_wdata = wr_data; s_ovf = fifo_over_flow; s_udf = fifo_under_flow;
    if (!s_rst) begin
      if (stall_pending) begin
        checks++;
        if (s_valid !== 1'b1 || s_data !== stall_data) begin
          errors++;
          $display("FAIL stall_hold: m_valid=%b m_data=%0d, required m_valid=1 m_data=%0d",
                   s_valid, s_data, stall_data);
        end
      end
      if (s_valid === 1'b1 && s_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: m_data=%0d delivered, required no word", s_data);
        end else begin
          exp = exp_q.pop_front();
          got.push_back(s_data);
          if (s_data !== exp) begin
            errors++;
            $display("FAIL stream_order: m_data=%0d, required %0d", s_data, exp);
          end
        end
      end
      if (s_rd_n === 1'b0) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL read_empty: fifo_rd_n=0 with model FIFO empty, required 1");
        end
      end
    end
    stall_pending = !s_rst && (s_valid === 1'b1) && !s_ready;
    stall_data    = s_data;
    @(posedge clk);
    #1;
    if (s_rst) begin
      fq.delete();
      exp_q.delete();
      fifo_dout = '0;
      exp_ovf   = 1'b0;
      exp_udf   = 1'b0;
    end else begin
      full = (fq.size() >= DEPTH);
      if (s_rd_n === 1'b0 && fq.size() > 0) fifo_dout = fq.pop_front();
      if (s_wr_n === 1'b0 && !full) begin
        fq.push_back(s_wdata);
        exp_q.push_back(s_wdata);
      end
      if ((s_wr_n === 1'b0 && full) || s_ovf) exp_ovf = 1'b1;
      if (s_udf) exp_udf = 1'b1;
    end
  endtask

  task automatic write_word(input logic [DATA_W-1:0] v);
    fifo_wr_n = 1'b0;
    wr_data   = v;
    tick();
    fifo_wr_n = 1'b1;
  endtask

  task automatic drain_all(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d words undelivered after %0d cycles, required 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; fifo_wr_n = 1'b1; wr_data = '0; m_ready = 1'b0;
    fifo_over_flow = 1'b0; fifo_under_flow = 1'b0; fifo_dout = '0;
    repeat (3) tick();
    checks++;
    if (level !== '0 || fifo_rd_n !== 1'b1 || m_valid !== 1'b0 || m_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: level=%0d rd_n=%b m_valid=%b m_data=%0d, required 0 1 0 0",
               level, fifo_rd_n, m_valid, m_data);
    end
    checks++;
    if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin
      errors++;
      $display("FAIL reset_errors: err_ovf=%b err_udf=%b, required 0 0", err_ovf, err_udf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    enable = 1'b0; m_ready = 1'b1;
    for (int v = 16; v >= 1; v--) write_word(DATA_W'(v));
    checks++;
    if (level !== CNT_W'(16)) begin
      errors++;
      $display("FAIL fill_level: level=%0d, required 16", level);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (fifo_rd_n !== 1'b0) begin
      errors++;
      $display("FAIL fill_rd_same_cycle: fifo_rd_n=%b, required 0", fifo_rd_n);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_latency_edge1: m_valid=%b, required 0", m_valid);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== DATA_W'(16 - i)) begin
        errors++;
        $display("FAIL fill_stream: cycle %0d m_valid=%b m_data=%0d, required 1 %0d",
                 i, m_valid, m_data, 16 - i);
      end
      tick();
    end
    checks++;
    if (m_valid !== 1'b0 || level !== '0 || fifo_rd_n !== 1'b1 || err_udf !== 1'b0) begin
      errors++;
      $display("FAIL fill_end: m_valid=%b level=%0d rd_n=%b err_udf=%b, required 0 0 1 0",
               m_valid, level, fifo_rd_n, err_udf);
    end
    enable = 1'b0;
  endtask

  task automatic test_overflow();
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_word(DATA_W'($urandom_range(0, 255)));
    write_word(DATA_W'(1));
    write_word(DATA_W'(1));
    checks++;
    if (level !== CNT_W'(fq.size()) || err_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL ovf_snoop: level=%0d err_ovf=%b, required %0d %b",
               level, err_ovf, fq.size(), exp_ovf);
    end
    enable = 1'b1;
    drain_all("ovf_drain", 60);
    checks++;
    if (err_ovf !== 1'b1 || level !== '0) begin
      errors++;
      $display("FAIL ovf_sticky: err_ovf=%b level=%0d, required 1 0", err_ovf, level);
    end
    enable = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: err_ovf=%b, required 0", err_ovf);
    end
  endtask

  task automatic test_empty();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (fifo_rd_n !== 1'b1 || m_valid !== 1'b0 || err_udf !== 1'b0) begin
        errors++;
        $display("FAIL empty_idle: cycle %0d rd_n=%b m_valid=%b err_udf=%b, required 1 0 0",
                 i, fifo_rd_n, m_valid, err_udf);
      end
      tick();
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int c = 0;
    enable = 1'b0; m_ready = 1'b0;
    for (int v = 10; v <= 13; v++) write_word(DATA_W'(v));
    got.delete();
    enable = 1'b1;
    while ((exp_q.size() != 0) && (c < 60)) begin
      m_ready = pat[c % 7];
      tick();
      c++;
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL bp_count: %0d words delivered, required 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== DATA_W'(10 + i)) begin
          errors++;
          $display("FAIL bp_order: word %0d=%0d, required %0d", i, got[i], 10 + i);
        end
      end
    end
    enable = 1'b0; m_ready = 1'b1;
    tick();
  endtask

  task automatic test_simul_wr_rd();
    enable = 1'b0; m_ready = 1'b1;
    write_word(DATA_W'(2));
    write_word(DATA_W'(3));
    got.delete();
    enable = 1'b1; fifo_wr_n = 1'b0; wr_data = DATA_W'(8);
    #1;
    checks++;
    if (fifo_rd_n !== 1'b0) begin
      errors++;
      $display("FAIL simul_rd: fifo_rd_n=%b, required 0", fifo_rd_n);
    end
    tick();
    fifo_wr_n = 1'b1;
    checks++;
    if (level !== CNT_W'(2)) begin
      errors++;
      $display("FAIL simul_level: level=%0d, required 2", level);
    end
    drain_all("simul", 20);
    checks++;
    if (got.size() != 3 || got[0] !== 8'd2 || got[1] !== 8'd3 || got[2] !== 8'd8) begin
      errors++;
      $display("FAIL simul_order: %0d words, first %0d, required 2,3,8",
               got.size(), (got.size() > 0) ? got[0] : 8'd0);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 6; i++) write_word(DATA_W'($urandom_range(1, 255)));
    enable = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (level !== '0 || fifo_rd_n !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 ||
        err_ovf !== 1'b0 || err_udf !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: level=%0d rd_n=%b m_valid=%b m_data=%0d, required 0 1 0 0",
               level, fifo_rd_n, m_valid, m_data);
    end
    rst = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale: cycle %0d m_valid=%b m_data=%0d, required m_valid=0",
                 i, m_valid, m_data);
      end
      tick();
    end
    got.delete();
    write_word(DATA_W'(77));
    write_word(DATA_W'(78));
    drain_all("rstmid", 20);
    checks++;
    if (got.size() != 2) begin
      errors++;
      $display("FAIL rstmid_after: %0d words delivered, required 2", got.size());
    end
    enable = 1'b0;
  endtask

  task automatic test_err_flags();
    fifo_under_flow = 1'b1;
    tick();
    fifo_under_flow = 1'b0;
    repeat (3) tick();
    checks++;
    if (err_udf !== exp_udf || err_ovf !== exp_ovf) begin
      errors++;
      $display("FAIL udf_flag: err_udf=%b err_ovf=%b, required %b %b",
               err_udf, err_ovf, exp_udf, exp_ovf);
    end
    fifo_over_flow = 1'b1;
    tick();
    fifo_over_flow = 1'b0;
    tick();
    checks++;
    if (err_ovf !== exp_ovf || err_udf !== exp_udf) begin
      errors++;
      $display("FAIL ovf_flag: err_ovf=%b err_udf=%b, required %b %b",
               err_ovf, err_udf, exp_ovf, exp_udf);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin
      errors++;
      $display("FAIL flag_clear: err_ovf=%b err_udf=%b, required 0 0", err_ovf, err_udf);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      m_ready = 1'($urandom_range(0, 1));
      if ((fq.size() < DEPTH) && ($urandom_range(0, 1) == 1)) begin
        fifo_wr_n = 1'b0;
        wr_data   = DATA_W'($urandom_range(0, 255));
      end else begin
        fifo_wr_n = 1'b1;
      end
      tick();
      checks++;
      if (level !== CNT_W'(fq.size())) begin
        errors++;
        $display("FAIL rand_level: cycle %0d level=%0d, required %0d", c, level, fq.size());
      end
    end
    fifo_wr_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    drain_all("rand_drain", 100);
    checks++;
    if (err_ovf !== exp_ovf || err_udf !== exp_udf || level !== '0) begin
      errors++;
      $display("FAIL rand_end: err_ovf=%b err_udf=%b level=%0d, required %b %b 0",
               err_ovf, err_udf, level, exp_ovf, exp_udf);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_empty();
    test_backpressure();
    test_simul_wr_rd();
    test_reset_mid();
    test_err_flags();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
